// File: rtl/syndrome_frame_loader_if.sv
// Syndrome word stream (valid/ready) between the measurement source and the frame loader.
interface syndrome_frame_loader_if #(
    parameter int INPUT_WIDTH = 8
) ();
    logic [INPUT_WIDTH-1:0] s_data;
    logic                   s_valid;
    logic                   s_last;
    logic                   s_ready;

    modport master (output s_data, s_valid, s_last, input s_ready);
    modport slave  (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/syndrome_frame_loader.sv
// Assembles streamed syndrome words into per-round frames (ping-pong buffered) and launches them
// to the stage controller. Optional round counter: SYNDROME_LOADER_ROUND_COUNT_EN.
module syndrome_frame_loader #(
    parameter int CODE_DISTANCE_X = 3,
    parameter int CODE_DISTANCE_Z = 2,
    parameter int INPUT_WIDTH     = 8,
    parameter int STAGE_WIDTH     = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    syndrome_frame_loader_if.slave        stream,
    input  logic [STAGE_WIDTH-1:0]        global_stage,
    output logic                          new_round_start,
    output logic [CODE_DISTANCE_X*CODE_DISTANCE_Z*
                  ((CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z)-1:0] measurements,
    output logic [1:0]                    frames_pending,
    output logic                          frame_error
`ifdef SYNDROME_LOADER_ROUND_COUNT_EN
    ,
    output logic [15:0]                   round_id
`endif
);
    localparam int MEASUREMENT_ROUNDS = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z;
    localparam int PU_COUNT           = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS;
    localparam int WORDS_PER_FRAME    = (PU_COUNT + INPUT_WIDTH - 1) / INPUT_WIDTH;
    localparam int WORD_IDX_WIDTH     = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam logic [WORD_IDX_WIDTH-1:0] LAST_IDX = WORD_IDX_WIDTH'(WORDS_PER_FRAME - 1);

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = '0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = STAGE_WIDTH'(1);

    typedef enum logic { FILL, DISCARD } fill_state_t;
    typedef enum logic { L_IDLE, L_WAIT } launch_state_t;

    fill_state_t   fill_state, fill_next;
    launch_state_t l_state, l_next;

    logic [1:0][PU_COUNT-1:0]   frame_buf;
    logic [1:0]                 full;
    logic                       fill_ptr;
    logic                       launch_ptr;
    logic [WORD_IDX_WIDTH-1:0]  word_idx;

    logic xfer, wr_en, frame_done, frame_bad, launch_fire, release_buf;

    // ---------------- fill FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) fill_state <= FILL;
        else       fill_state <= fill_next;
    end

    always_comb begin
        fill_next = fill_state;
        case (fill_state)
            FILL:    if (xfer && word_idx == LAST_IDX && !stream.s_last) fill_next = DISCARD;
            DISCARD: if (xfer && stream.s_last) fill_next = FILL;
            default: fill_next = FILL;
        endcase
    end

    // The buffer under fill_ptr is always the next one in FIFO order, so it alone decides readiness.
    assign stream.s_ready = !reset && (fill_state == DISCARD || !full[fill_ptr]);
    assign xfer           = stream.s_valid && stream.s_ready;

    always_comb begin
        wr_en      = 1'b0;
        frame_done = 1'b0;
        frame_bad  = 1'b0;
        if (fill_state == FILL && xfer) begin
            wr_en      = 1'b1;
            frame_done = (word_idx == LAST_IDX) && stream.s_last;
            frame_bad  = (word_idx == LAST_IDX) != stream.s_last;
        end
    end

    // ---------------- launch FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) l_state <= L_IDLE;
        else       l_state <= l_next;
    end

    always_comb begin
        l_next = l_state;
        case (l_state)
            L_IDLE:  if (launch_fire) l_next = L_WAIT;
            L_WAIT:  if (release_buf) l_next = L_IDLE;
            default: l_next = L_IDLE;
        endcase
    end

    always_comb begin
        launch_fire = (l_state == L_IDLE) && full[launch_ptr] && (global_stage == STAGE_IDLE);
        release_buf = (l_state == L_WAIT) && (global_stage == STAGE_MEASUREMENT_LOADING);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_buf       <= '0;
            full            <= '0;
            fill_ptr        <= 1'b0;
            launch_ptr      <= 1'b0;
            word_idx        <= '0;
            frame_error     <= 1'b0;
            new_round_start <= 1'b0;
            measurements    <= '0;
        end else begin
            new_round_start <= launch_fire;
            // Word k lands on frame bits [k*INPUT_WIDTH +: INPUT_WIDTH]; bits past PU_COUNT are dropped.
            for (int b = 0; b < PU_COUNT; b++) begin
                if (wr_en && WORD_IDX_WIDTH'(b / INPUT_WIDTH) == word_idx)
                    frame_buf[fill_ptr][b] <= stream.s_data[b % INPUT_WIDTH];
            end
            if (wr_en) begin
                if (stream.s_last || word_idx == LAST_IDX) word_idx <= '0;
                else                                       word_idx <= word_idx + 1'b1;
            end
            if (frame_bad) frame_error <= 1'b1;
            // Completion and release always target different buffers.
            if (frame_done) begin
                full[fill_ptr] <= 1'b1;
                fill_ptr       <= ~fill_ptr;
            end
            if (release_buf) begin
                full[launch_ptr] <= 1'b0;
                launch_ptr       <= ~launch_ptr;
            end
            if (launch_fire) measurements <= frame_buf[launch_ptr];
        end
    end

`ifdef SYNDROME_LOADER_ROUND_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)            round_id <= '0;
        else if (launch_fire) round_id <= round_id + 16'd1;
    end
`endif

    assign frames_pending = {1'b0, full[0]} + {1'b0, full[1]};
endmodule

// File: tb/tb_syndrome_frame_loader.sv
// Directed self-checking bench for syndrome_frame_loader at default parameters.
module tb_syndrome_frame_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  global_stage;
    logic        new_round_start;
    logic [17:0] measurements;
    logic [1:0]  frames_pending;
    logic        frame_error;
`ifdef SYNDROME_LOADER_ROUND_COUNT_EN
    logic [15:0] round_id;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int pulse_cnt = 0;
    int base;
    logic [17:0] held;

    syndrome_frame_loader_if #(.INPUT_WIDTH(8)) bus ();

    syndrome_frame_loader dut (
        .clk             (clk),
        .reset           (reset),
        .stream          (bus),
        .global_stage    (global_stage),
        .new_round_start (new_round_start),
        .measurements    (measurements),
        .frames_pending  (frames_pending),
        .frame_error     (frame_error)
`ifdef SYNDROME_LOADER_ROUND_COUNT_EN
        ,
        .round_id        (round_id)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (new_round_start === 1'b1) pulse_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] d, input logic last);
        int n = 0;
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        bus.s_last  = last;
        while (bus.s_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("send_timeout", 32'd0, 32'd1);
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
        send_word(w0, 1'b0);
        send_word(w1, 1'b0);
        send_word(w2, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        global_stage = 3'd0;
        bus.s_data = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
        repeat (3) tick();
        chk("rst_nrs", new_round_start, 0);
        chk("rst_meas", measurements, 0);
        chk("rst_pending", frames_pending, 0);
        chk("rst_err", frame_error, 0);
        chk("rst_ready", bus.s_ready, 0);
`ifdef SYNDROME_LOADER_ROUND_COUNT_EN
        chk("rst_round_id", round_id, 0);
`endif
        reset = 1'b0;
        tick();
        chk("ready_after_rst", bus.s_ready, 1);

        // single frame
        send_frame(8'hA5, 8'h3C, 8'h02);
        chk("t1_nrs_pre", new_round_start, 0);
        chk("t1_pending", frames_pending, 1);
        tick();
        chk("t1_nrs", new_round_start, 1);
        chk("t1_meas", measurements, 18'h23CA5);
        global_stage = 3'd1;
        tick();
        chk("t1_nrs_once", new_round_start, 0);
        chk("t1_released", frames_pending, 0);
        global_stage = 3'd0;

        // launch hold: stage stays idle for 4 cycles after the pulse
        send_frame(8'h11, 8'h22, 8'h01);
        base = pulse_cnt;
        tick();
        chk("hold_nrs", new_round_start, 1);
        chk("hold_meas", measurements, 18'h12211);
        held = measurements;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_nrs_low", new_round_start, 0);
            chk("hold_meas_stable", measurements, held);
            chk("hold_pending", frames_pending, 1);
        end
        global_stage = 3'd1;
        tick();
        chk("hold_release", frames_pending, 0);
        chk("hold_meas_after", measurements, 18'h12211);
        chk("hold_one_pulse", pulse_cnt - base, 1);
        global_stage = 3'd2;

        // backpressure with controller busy
        send_frame(8'h01, 8'h02, 8'h03);
        send_frame(8'hFF, 8'h00, 8'h00);
        chk("bp_ready_low", bus.s_ready, 0);
        chk("bp_pending2", frames_pending, 2);
        global_stage = 3'd0;
        tick();
        chk("bp_launch_a", measurements, 18'h30201);
        global_stage = 3'd1;
        #1;
        chk("bp_ready_still_low", bus.s_ready, 0);
        tick();
        chk("bp_ready_back", bus.s_ready, 1);
        chk("bp_pending1", frames_pending, 1);
        global_stage = 3'd2;
        send_frame(8'h00, 8'h80, 8'h07);
        chk("bp_pending_c", frames_pending, 2);
        global_stage = 3'd0;
        tick();
        chk("bp_launch_b", measurements, 18'h000FF);
        global_stage = 3'd1;
        tick();
        global_stage = 3'd0;
        tick();
        chk("bp_launch_c_nrs", new_round_start, 1);
        chk("bp_launch_c", measurements, 18'h38000);
        global_stage = 3'd1;
        tick();
        chk("bp_drained", frames_pending, 0);
        global_stage = 3'd0;

        // short frame
        base = pulse_cnt;
        send_word(8'h55, 1'b0);
        send_word(8'h66, 1'b1);
        repeat (3) tick();
        chk("short_err", frame_error, 1);
        chk("short_pending", frames_pending, 0);
        chk("short_no_launch", pulse_cnt - base, 0);
        send_frame(8'h0F, 8'hF0, 8'h01);
        tick();
        chk("short_next_nrs", new_round_start, 1);
        chk("short_next_meas", measurements, 18'h1F00F);
        global_stage = 3'd1;
        tick();
        global_stage = 3'd0;

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("err_cleared", frame_error, 0);

        // missing s_last: third word without last forces a discard run
        base = pulse_cnt;
        send_word(8'h10, 1'b0);
        send_word(8'h20, 1'b0);
        send_word(8'h30, 1'b0);
        chk("miss_err", frame_error, 1);
        chk("miss_discard_ready", bus.s_ready, 1);
        send_word(8'h40, 1'b0);
        send_word(8'h50, 1'b1);
        repeat (2) tick();
        chk("miss_pending", frames_pending, 0);
        chk("miss_no_launch", pulse_cnt - base, 0);
        send_frame(8'h12, 8'h34, 8'h02);
        tick();
        chk("miss_next_nrs", new_round_start, 1);
        chk("miss_next_meas", measurements, 18'h23412);
        global_stage = 3'd1;
        tick();
        global_stage = 3'd2;

        // reset mid-frame with one frame pending
        send_frame(8'hAA, 8'hBB, 8'h01);
        send_word(8'h01, 1'b0);
        send_word(8'h02, 1'b0);
        chk("mid_pending_pre", frames_pending, 1);
        reset = 1'b1;
        tick();
        tick();
        chk("mid_nrs", new_round_start, 0);
        chk("mid_meas", measurements, 0);
        chk("mid_pending", frames_pending, 0);
        chk("mid_err", frame_error, 0);
        chk("mid_ready", bus.s_ready, 0);
        reset = 1'b0;
        global_stage = 3'd0;
        base = pulse_cnt;
        repeat (3) tick();
        chk("mid_no_stale_launch", pulse_cnt - base, 0);
`ifdef SYNDROME_LOADER_ROUND_COUNT_EN
        chk("mid_round_id0", round_id, 0);
`endif
        send_frame(8'h9A, 8'hBC, 8'h03);
        tick();
        chk("mid_next_nrs", new_round_start, 1);
        chk("mid_next_meas", measurements, 18'h3BC9A);
`ifdef SYNDROME_LOADER_ROUND_COUNT_EN
        chk("mid_round_id1", round_id, 1);
`endif
        global_stage = 3'd1;
        tick();
        chk("mid_released", frames_pending, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/syndrome_frame_loader.md
Name: syndrome_frame_loader

Overview:
- Upstream feeder of the unified stage controller in the single-FPGA decoder.
- Accepts syndrome measurement bits as a valid/ready word stream and assembles them into full per-round frames of PU_COUNT bits in a two-entry ping-pong buffer.
- Pulses new_round_start when the controller is in STAGE_IDLE. Holds the frame on measurements so PEs can latch it during STAGE_MEASUREMENT_LOADING.

Parameters:
- CODE_DISTANCE_X, 3, X code distance.
- CODE_DISTANCE_Z, 2, Z code distance.
- INPUT_WIDTH, 8, stream word width in bits.
- Derived, not overridable:
  - MEASUREMENT_ROUNDS = max(X,Z).
  - PU_COUNT = X*Z*MEASUREMENT_ROUNDS, which is 18 at defaults.
  - WORDS_PER_FRAME = ceil(PU_COUNT/INPUT_WIDTH), which is 3 at defaults.
  - WORD_IDX_WIDTH = max(1, clog2(WORDS_PER_FRAME)).

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- s_data  input  INPUT_WIDTH  syndrome word. Word k carries frame bits [k*INPUT_WIDTH +: INPUT_WIDTH].
- s_valid  input  1  s_data valid.
- s_last  input  1  marks the final word of a frame.
- s_ready  output  1  loader accepts a word this cycle.
- global_stage  input  STAGE_WIDTH  stage from the controller. Codes come from the shared parameters include: STAGE_IDLE=0, STAGE_MEASUREMENT_LOADING=1.
- new_round_start  output  1  single-cycle, registered launch pulse.
- measurements  output  PU_COUNT  frame presented to the PEs.
- frames_pending  output  2  number of complete frames buffered, 0..2.
- frame_error  output  1  sticky framing error flag.

Behaviour:
- Reset values: new_round_start=0, measurements=0, frames_pending=0, frame_error=0, s_ready=0 while reset is high.
- Reset mid-frame discards any partial frame. Reset drops both buffered frames and any outstanding launch.
- A word transfers on s_valid && s_ready.

Fill FSM (FILL, DISCARD):
- FILL:
  - s_ready=1 iff a free buffer exists.
  - Each accepted word is written at word_idx into the fill buffer, then word_idx increments.
  - Accepted word with word_idx==WORDS_PER_FRAME-1 and s_last=1: the buffer is marked full, word_idx=0, and the fill pointer toggles.
  - Accepted word with s_last=1 and word_idx<WORDS_PER_FRAME-1: the frame is discarded, frame_error is set, word_idx=0, and the state stays in FILL.
  - Accepted word with word_idx==WORDS_PER_FRAME-1 and s_last=0: the frame is discarded, frame_error is set, and the FSM goes to DISCARD.
- DISCARD:
  - s_ready=1.
  - Words are dropped up to and including the next word with s_last=1, then the FSM returns to FILL with word_idx=0.
- Bits of the last word above PU_COUNT are ignored.

Launch FSM (L_IDLE, L_WAIT):
- L_IDLE: if a full buffer exists and global_stage==STAGE_IDLE, then on the next edge:
  - new_round_start=1 for exactly one cycle;
  - measurements is loaded from the oldest full buffer;
  - the FSM goes to L_WAIT.
- L_WAIT:
  - No further launch is issued.
  - When global_stage==STAGE_MEASUREMENT_LOADING is observed, the launched buffer is released (marked free) and the FSM returns to L_IDLE.
  - measurements holds its value until the next launch and is never changed while in L_WAIT or during loading.
- Launches stay in FIFO order across the two buffers.
- Simultaneous events:
  - Frame completion and buffer release in the same cycle: frames_pending nets to unchanged.
  - Release frees a buffer while the fill side is stalled: s_ready rises the following cycle.
- frames_pending counts full buffers, including one launched but not yet released.
- frame_error clears only on reset.

Optional Feature:
- Macro: SYNDROME_LOADER_ROUND_COUNT_EN.
- When defined:
  - Adds output round_id [15:0], reset 0.
  - round_id increments on each new_round_start pulse, in the same cycle measurements updates.
  - It wraps from 65535 to 0.
  - Downstream result logic tags results with it.
- When not defined: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Single frame, defaults. Stimulus: words 0xA5, 0x3C, 0x02 with s_last on the third; global_stage=0. Response:
  - new_round_start pulses one cycle after the third transfer;
  - measurements=18'h23CA5;
  - frames_pending goes 1→0 after the controller shows stage 1.
- Backpressure. Stimulus: stream 3 frames while global_stage is held at 2. Response:
  - after 2 frames, s_ready=0 and frames_pending=2;
  - returning the stage to 0 then 1 releases a buffer, s_ready returns to 1 the next cycle, and frame 3 completes.
- Short frame. Stimulus: s_last on word index 1. Response:
  - frame_error=1 and no launch;
  - a following well-formed frame launches normally.
- Missing s_last. Stimulus: 5 words with s_last only on word 5. Response:
  - frame_error=1 and the words are discarded;
  - the next 3-word frame launches.
- Launch hold. Stimulus: keep global_stage=0 for 4 cycles after a new_round_start pulse, then 1. Response:
  - only one pulse is issued;
  - measurements is stable throughout;
  - release happens on the stage-1 cycle.
- Reset mid-frame. Stimulus: reset after word 2 with one full frame pending. Response:
  - all outputs are 0 and frames_pending=0;
  - the next complete frame launches with correct data (round_id=0→1 when SYNDROME_LOADER_ROUND_COUNT_EN is defined).
